// File: rtl/uart_report_ctrl.sv
// uart_report_ctrl: streams each sensor sample as an ASCII hex line
// (prefix, uppercase hex digits MSB first, optional CR LF) over a byte UART.
module uart_report_ctrl #(
    parameter int         DATA_W    = 16,
    parameter logic [7:0] PREFIX    = 8'h54,
    parameter bit         TERM_CRLF = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              frame_busy,
    output logic              pending,
    output logic [7:0]        overrun_cnt
);

    localparam int NDIG = DATA_W / 4;
    localparam int L    = 1 + NDIG + (TERM_CRLF ? 2 : 0);
    localparam int KW   = 4;

    localparam logic [KW-1:0] K_LAST = KW'(L - 1);

    if (DATA_W < 4 || DATA_W > 32 || (DATA_W % 4) != 0) begin : g_bad_w
        $error("DATA_W must be a multiple of 4 in 4..32");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [DATA_W-1:0] frame_q;
    logic [DATA_W-1:0] pend_q;
    logic              accept;

    assign accept = enable & sample_valid;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] byte_at(
        input logic [KW-1:0]     idx,
        input logic [DATA_W-1:0] frame
    );
        logic [DATA_W-1:0] sh;
        int                ki;
        ki = int'(idx);
        sh = '0;
        if (ki == 0) begin
            return PREFIX;
        end
        if (ki <= NDIG) begin
            sh = frame >> (4 * (NDIG - ki));
            return hex_char(sh[3:0]);
        end
        if (ki == NDIG + 1) begin
            return 8'h0D;
        end
        return 8'h0A;
    endfunction

    // Frame sequencer, pending buffer and overrun counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            k           <= '0;
            frame_q     <= '0;
            pend_q      <= '0;
            pending     <= 1'b0;
            overrun_cnt <= 8'h00;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            frame_busy  <= 1'b0;
        end else begin
            tx_start <= 1'b0;

            // Mid-frame samples park in the pending buffer; newest wins.
            if (accept && state != IDLE) begin
                pend_q  <= sample_data;
                pending <= 1'b1;
                if (pending && overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        // A fresh sample supersedes a waiting one.
                        frame_q    <= sample_data;
                        pending    <= 1'b0;
                        k          <= '0;
                        frame_busy <= 1'b1;
                        state      <= LOAD;
                        if (pending && overrun_cnt != 8'hFF) begin
                            overrun_cnt <= overrun_cnt + 8'd1;
                        end
                    end else if (pending) begin
                        frame_q    <= pend_q;
                        pending    <= 1'b0;
                        k          <= '0;
                        frame_busy <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data <= byte_at(k, frame_q);
                    state   <= ISSUE;
                end
                ISSUE: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (k == K_LAST) begin
                            frame_busy <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            k     <= k + KW'(1);
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_report_ctrl.sv
// tb_uart_report_ctrl: directed checks of the hex line reporter against
// a simple busy-for-N-cycles transmitter model.
module tb_uart_report_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        enable;
    logic        sv;
    logic [15:0] sd;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        fb;
    logic        pend;
    logic [7:0]  ovr;

    logic        sv8;
    logic [7:0]  sd8;
    logic        tx_busy8;
    logic        tx_start8;
    logic [7:0]  tx_data8;
    logic        fb8;
    logic        pend8;
    logic [7:0]  ovr8;

    uart_report_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .sample_valid(sv),
        .sample_data (sd),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .frame_busy  (fb),
        .pending     (pend),
        .overrun_cnt (ovr)
    );

    uart_report_ctrl #(
        .DATA_W   (8),
        .PREFIX   (8'h54),
        .TERM_CRLF(1'b0)
    ) dut8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .sample_valid(sv8),
        .sample_data (sd8),
        .tx_busy     (tx_busy8),
        .tx_start    (tx_start8),
        .tx_data     (tx_data8),
        .frame_busy  (fb8),
        .pending     (pend8),
        .overrun_cnt (ovr8)
    );

    int   bcnt = 0;
    int   bcnt8 = 0;
    logic hold = 1'b0;
    logic hold8 = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) bcnt <= 0;
        else if (tx_start && bcnt == 0) bcnt <= 20;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end

    always @(posedge clk) begin
        if (!reset_n) bcnt8 <= 0;
        else if (tx_start8 && bcnt8 == 0) bcnt8 <= 5;
        else if (bcnt8 > 0) bcnt8 <= bcnt8 - 1;
    end

    assign tx_busy  = (bcnt != 0) || hold;
    assign tx_busy8 = (bcnt8 != 0) || hold8;

    logic [7:0] q[$];
    logic [7:0] q8[$];
    int   viol = 0;
    int   gap = 0;
    int   starts8 = 0;
    logic ps = 1'b0;
    logic ps8 = 1'b0;

    always @(negedge clk) begin
        if (tx_start) begin
            q.push_back(tx_data);
            if (ps || tx_busy) viol++;
        end
        if (tx_start8) begin
            q8.push_back(tx_data8);
            starts8++;
            if (ps8 || tx_busy8) viol++;
        end
        if (!fb && pend) gap++;
        ps  = tx_start;
        ps8 = tx_start8;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] d);
        @(negedge clk);
        sv = 1'b1;
        sd = d;
        @(negedge clk);
        sv = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d);
        @(negedge clk);
        sv8 = 1'b1;
        sd8 = d;
        @(negedge clk);
        sv8 = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit use8,
                             input int budget);
        int c;
        c = 0;
        while (c < budget &&
               (use8 ? (fb8 || pend8 || tx_busy8)
                     : (fb || pend || tx_busy))) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_tmo"}, 32'(c >= budget), 32'd0);
    endtask

    task automatic expect_frame(input string tag, input bit use8,
                                input int n, input logic [87:0] exp);
        int sz;
        logic [7:0] b;
        sz = use8 ? q8.size() : q.size();
        check({tag, "_len"}, 32'(sz >= n), 32'd1);
        if (sz >= n) begin
            for (int i = 0; i < n; i++) begin
                b = use8 ? q8.pop_front() : q.pop_front();
                check($sformatf("%s_b%0d", tag, i), 32'(b),
                      32'(exp[(n-1-i)*8 +: 8]));
            end
        end
    endtask

    initial begin
        int lat;
        int s0;
        int c;

        reset_n = 1'b0;
        enable  = 1'b1;
        sv      = 1'b0;
        sd      = '0;
        sv8     = 1'b0;
        sd8     = '0;
        repeat (3) @(negedge clk);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_fb", 32'(fb), 32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        send(16'h1A3F);
        lat = 0;
        while (!tx_start && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd2);
        check("first_byte", 32'(tx_data), 32'h54);
        wait_idle("f1", 1'b0, 400);
        check("f1_count", 32'(q.size()), 32'd7);
        expect_frame("f1", 1'b0, 7, 88'h54314133460D0A);
        check("f1_fb", 32'(fb), 32'd0);
        check("f1_ovr", 32'(ovr), 32'd0);

        gap = 0;
        send(16'h09AF);
        repeat (30) @(negedge clk);
        send(16'hFFFF);
        check("b2b_pend", 32'(pend), 32'd1);
        wait_idle("b2b", 1'b0, 800);
        expect_frame("b2b_a", 1'b0, 7, 88'h54303941460D0A);
        expect_frame("b2b_b", 1'b0, 7, 88'h54464646460D0A);
        check("b2b_gap", 32'(gap), 32'd1);

        send(16'h0001);
        repeat (30) @(negedge clk);
        send(16'h0002);
        send(16'h0003);
        check("ovr_one", 32'(ovr), 32'd1);
        wait_idle("ovr", 1'b0, 800);
        expect_frame("ovr_a", 1'b0, 7, 88'h54303030310D0A);
        expect_frame("ovr_b", 1'b0, 7, 88'h54303030330D0A);

        hold = 1'b1;
        send(16'h0005);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            sv = 1'b1;
            sd = 16'(i);
        end
        @(negedge clk);
        sv = 1'b0;
        check("ovr_sat", 32'(ovr), 32'd255);
        check("hold_q", 32'(q.size()), 32'd0);
        hold = 1'b0;
        wait_idle("sat", 1'b0, 800);
        expect_frame("sat_a", 1'b0, 7, 88'h54303030350D0A);
        expect_frame("sat_b", 1'b0, 7, 88'h54303132420D0A);

        hold8 = 1'b1;
        s0 = starts8;
        send8(8'hC5);
        repeat (50) @(negedge clk);
        check("hold_nostart", 32'(starts8 - s0), 32'd0);
        hold8 = 1'b0;
        wait_idle("n8", 1'b1, 200);
        check("n8_starts", 32'(starts8 - s0), 32'd3);
        expect_frame("n8", 1'b1, 3, 88'h544335);

        send(16'h1234);
        c = 0;
        while (q.size() < 3 && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("rst_mid_tmo", 32'(c >= 300), 32'd0);
        send(16'h5555);
        check("pre_rst_pend", 32'(pend), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_start", 32'(tx_start), 32'd0);
        check("mrst_fb", 32'(fb), 32'd0);
        check("mrst_pend", 32'(pend), 32'd0);
        check("mrst_ovr", 32'(ovr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        send(16'h0000);
        wait_idle("z", 1'b0, 400);
        check("z_count", 32'(q.size()), 32'd7);
        expect_frame("z", 1'b0, 7, 88'h54303030300D0A);

        enable = 1'b0;
        send(16'h1111);
        send(16'h2222);
        send(16'h3333);
        repeat (20) @(negedge clk);
        check("dis_q", 32'(q.size()), 32'd0);
        check("dis_fb", 32'(fb), 32'd0);
        check("dis_pend", 32'(pend), 32'd0);
        check("dis_ovr", 32'(ovr), 32'd0);
        enable = 1'b1;
        send(16'hABCD);
        repeat (40) @(negedge clk);
        enable = 1'b0;
        send(16'h7777);
        wait_idle("en", 1'b0, 400);
        check("en_count", 32'(q.size()), 32'd7);
        expect_frame("en", 1'b0, 7, 88'h54414243440D0A);
        check("en_pend", 32'(pend), 32'd0);

        check("protocol", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_report_ctrl.md
Name: uart_report_ctrl

Overview:
- Sequences the UART transmitter to stream each temperature-sensor sample as an ASCII hex line: PREFIX, DATA_W/4 uppercase hex digits (MSB first), then optional CR LF.
- Sits between the RO-counter measurement logic and the byte-level UART transmitter. Drives that transmitter's tx_start/tx_data and watches its tx_busy.
- Holds a one-deep pending buffer so samples that arrive mid-frame are not lost; a sample that overwrites the buffer is counted as an overrun.

Parameters:
- DATA_W, 16, sample width. Must be a multiple of 4, range 4..32. NDIG = DATA_W/4.
- PREFIX, 8'h54, first byte of every frame ('T').
- TERM_CRLF, 1, 1 = append 8'h0D 8'h0A; 0 = no terminator.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, reset: synchronous, active-low.
- enable, input, 1, 0 = ignore new samples; a frame already in progress still completes.
- sample_valid, input, 1, one-cycle strobe marking a new sample.
- sample_data, input, DATA_W, sample value, qualified by sample_valid.
- tx_busy, input, 1, transmitter busy (low only when it is idle).
- tx_start, output, 1, registered one-cycle request to the transmitter.
- tx_data, output, 8, registered byte for the transmitter.
- frame_busy, output, 1, high while a frame is being sent.
- pending, output, 1, pending buffer holds a sample.
- overrun_cnt, output, 8, saturating count of pending-buffer overwrites.

Behaviour:
- Reset values: tx_start=0, tx_data=8'h00, frame_busy=0, pending=0, overrun_cnt=0, state=IDLE, byte index=0.
- A reset asserted mid-frame aborts the frame at the next edge. No partial-frame recovery.
- Frame length L = 1 + NDIG + (TERM_CRLF ? 2 : 0). Default L = 7.
- Byte index k = 0..L-1:
  - k=0: PREFIX.
  - k=1..NDIG: hex digit of nibble (NDIG-k) of the frame's sample.
  - Then 8'h0D, 8'h0A.
- Hex encoding: nibble 0-9 -> 8'h30+n; nibble 10-15 -> 8'h41+(n-10). Uppercase only.
- Samples are captured into a frame register at frame start. Input changes during a frame do not affect bytes already scheduled.
- Sample acceptance (only when enable=1):
  - IDLE with no pending: the sample goes directly to the frame register and a frame starts.
  - Otherwise the sample writes the pending buffer. If pending was already 1, overrun_cnt increments, saturating at 255, and the newest sample wins.
- State machine:
  - IDLE: on an accepted sample at edge t, or pending=1, load the frame register (from pending if pending=1, clearing it), set k=0, frame_busy=1 -> LOAD.
  - LOAD: register tx_data = byte k -> ISSUE.
  - ISSUE: if tx_busy=0, tx_start=1 for exactly one cycle -> WAIT_ACK. If tx_busy=1, hold in ISSUE with tx_start=0.
  - WAIT_ACK: wait for tx_busy=1 -> WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0. Then, if k=L-1: frame_busy=0 -> IDLE. Else k=k+1 -> LOAD.
- tx_data stays stable from LOAD until the next LOAD.
- Latency: a sample accepted at edge t gives tx_data=PREFIX at t+2 and tx_start high in the cycle after t+2, provided tx_busy=0.
- Simultaneous events:
  - A sample arriving in the same cycle as the WAIT_DONE -> IDLE transition goes to the pending buffer (overrun rule applies). IDLE then starts the next frame from pending one cycle later.
  - A sample arriving in IDLE while pending=1 overwrites pending (overrun counted), and that sample becomes the frame.
- tx_start is never high in two consecutive cycles and never high while tx_busy=1.

Test Plan:
- Sample 16'h1A3F, transmitter model asserting busy for 20 cycles per byte -> exactly 7 tx_start pulses carrying 54 31 41 33 46 0D 0A, then frame_busy=0 and overrun_cnt=0.
- Samples 16'h09AF then 16'hFFFF (the second issued mid-frame) -> pending=1 after the second; two frames 54 30 39 41 46 0D 0A and 54 46 46 46 46 0D 0A back-to-back with no IDLE gap beyond one cycle.
- Three samples 0x0001, 0x0002, 0x0003 during one frame -> overrun_cnt=1; the frame after 0x0001 carries 0x0003. Then 300 overwrites -> overrun_cnt saturates at 255.
- tx_busy held high for 50 cycles at ISSUE -> tx_start stays 0 throughout and pulses exactly once after busy falls. TERM_CRLF=0, DATA_W=8, sample 8'hC5 -> 54 43 35 only.
- reset_n low during byte 3 -> next edge: tx_start=0, frame_busy=0, pending=0, overrun_cnt=0. A subsequent sample 16'h0000 sends 54 30 30 30 30 0D 0A.
- enable=0 with sample_valid pulses -> no frame, pending=0, counter unchanged. enable dropped mid-frame -> the current frame completes intact.
